// File: rtl/i_delay_tap_ctrl.sv
// i_delay_tap_ctrl: sequences one I_DELAY primitive to a requested tap.
// A request carries a target tap and an optional reload flag. The
// controller optionally pulses DLY_LOAD and then steps DLY_ADJ one tap at a
// time, re-deciding the direction on every compare, until DLY_TAP_VALUE
// matches the (clamped) target.
//
// Optional feature, enabled by defining IDLY_CTRL_STEP_TIMEOUT_EN:
//   a step watchdog counts consecutive adjust steps that leave the tap
//   unchanged. When the count reaches TIMEOUT_CYCLES, err_o is raised and
//   the sequence ends through DONE. Without the macro, err_o is tied low.
//
// Handshake: req_i is sampled only while idle. Acceptance is reported by a
// one-cycle ack_o pulse in the cycle after the accepting edge. busy_o covers
// the whole sequence up to and including the done_o cycle. A req_i that
// arrives while busy is dropped, not queued.
//
// Output timing relative to the FSM state:
//   - ack_o and done_o are raised on the edge that enters the next state.
//   - dly_ld_o and dly_adj_o are raised on the edge that leaves LOAD/ADJ, so
//     dly_incdec_o (set when leaving CMP) has been stable for one full cycle
//     before dly_adj_o rises.
module i_delay_tap_ctrl #(
  parameter int TAP_W          = 6,
  parameter int MAX_TAP        = 63,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic             load_i,
  input  logic [TAP_W-1:0] target_tap_i,
  output logic             ack_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [TAP_W-1:0] cur_tap_o,
  output logic             dly_ld_o,
  output logic             dly_adj_o,
  output logic             dly_incdec_o,
  input  logic [TAP_W-1:0] dly_tap_value_i
);

  localparam logic [TAP_W-1:0] MAX_TAP_V   = TAP_W'(MAX_TAP);
  localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  // Reject parameter values the counters cannot represent.
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 1..255");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    WAIT = 3'd2,
    CMP  = 3'd3,
    ADJ  = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t           state_q;
  logic [TAP_W-1:0] target_q;
  logic [7:0]       settle_cnt_q;
  logic             ack_q;
  logic             busy_q;
  logic             done_q;
  logic [TAP_W-1:0] cur_tap_q;
  logic             ld_q;
  logic             adj_q;
  logic             incdec_q;
  logic [TAP_W-1:0] tgt_clamp_d;

  // Clamp the incoming target so no step is ever requested past MAX_TAP.
  always_comb begin
    tgt_clamp_d = (target_tap_i > MAX_TAP_V) ? MAX_TAP_V : target_tap_i;
  end

`ifdef IDLY_CTRL_STEP_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  logic             err_q;
  logic             step_pend_q;
  logic [TAP_W-1:0] prev_tap_q;
  logic [TO_W-1:0]  unch_cnt_q;
  logic [TO_W-1:0]  unch_cnt_d;
  logic             timeout_hit_d;

  // Next unchanged-step count as seen by the current compare.
  always_comb begin
    unch_cnt_d    = '0;
    timeout_hit_d = 1'b0;
    if (step_pend_q && (dly_tap_value_i == prev_tap_q)) begin
      unch_cnt_d = unch_cnt_q + TO_W'(1);
    end
    timeout_hit_d = (unch_cnt_d == TO_LIMIT);
  end

  // Watchdog state: last pre-step tap, unchanged-step count, sticky error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q       <= 1'b0;
      step_pend_q <= 1'b0;
      prev_tap_q  <= '0;
      unch_cnt_q  <= '0;
    end else begin
      if (state_q == IDLE && req_i) begin
        err_q       <= 1'b0;
        step_pend_q <= 1'b0;
        unch_cnt_q  <= '0;
      end else if (state_q == CMP) begin
        unch_cnt_q <= unch_cnt_d;
        if (dly_tap_value_i != target_q) begin
          if (timeout_hit_d) begin
            err_q <= 1'b1;
          end else begin
            step_pend_q <= 1'b1;
            prev_tap_q  <= dly_tap_value_i;
          end
        end
      end
    end
  end

  assign err_o = err_q;
`else
  logic timeout_hit_d;

  // No watchdog: compares never time out.
  always_comb begin
    timeout_hit_d = 1'b0;
  end

  assign err_o = 1'b0;
`endif

  // Main sequencing FSM with registered control outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      target_q     <= '0;
      settle_cnt_q <= '0;
      ack_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cur_tap_q    <= '0;
      ld_q         <= 1'b0;
      adj_q        <= 1'b0;
      incdec_q     <= 1'b0;
    end else begin
      ack_q  <= 1'b0;
      done_q <= 1'b0;
      ld_q   <= 1'b0;
      adj_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (req_i) begin
            target_q <= tgt_clamp_d;
            ack_q    <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= load_i ? LOAD : CMP;
          end
        end
        LOAD: begin
          ld_q         <= 1'b1;
          settle_cnt_q <= '0;
          state_q      <= WAIT;
        end
        WAIT: begin
          if (settle_cnt_q == SETTLE_LAST) begin
            state_q <= CMP;
          end else begin
            settle_cnt_q <= settle_cnt_q + 8'd1;
          end
        end
        CMP: begin
          cur_tap_q <= dly_tap_value_i;
          if (dly_tap_value_i == target_q) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (timeout_hit_d) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            incdec_q <= (dly_tap_value_i < target_q);
            state_q  <= ADJ;
          end
        end
        ADJ: begin
          adj_q        <= 1'b1;
          settle_cnt_q <= '0;
          state_q      <= WAIT;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack_o        = ack_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign cur_tap_o    = cur_tap_q;
  assign dly_ld_o     = ld_q;
  assign dly_adj_o    = adj_q;
  assign dly_incdec_o = incdec_q;

endmodule

// File: tb/tb_i_delay_tap_ctrl.sv
// Directed testbench for i_delay_tap_ctrl with a behavioural I_DELAY model.
// Cycle k is the period right after clock edge k-1. The accepting edge is
// edge 0. All outputs are sampled on the falling edge.
module tb_i_delay_tap_ctrl;

  localparam int TAP_W   = 6;
  localparam int MAX_TAP = 50;
  localparam int SETTLE  = 4;

  // Clock and reset.
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             req = 1'b0;
  logic             load = 1'b0;
  logic [TAP_W-1:0] target = '0;
  logic             ack_o, busy_o, done_o, err_o;
  logic [TAP_W-1:0] cur_tap_o;
  logic             dly_ld_o, dly_adj_o, dly_incdec_o;
  logic [TAP_W-1:0] tap_q = '0;

  // I_DELAY model controls.
  logic             preset_en = 1'b0;
  logic [TAP_W-1:0] preset_val = '0;
  logic             ignore_adj = 1'b0;

  i_delay_tap_ctrl #(
    .TAP_W(TAP_W), .MAX_TAP(MAX_TAP), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .load_i(load), .target_tap_i(target),
    .ack_o(ack_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .cur_tap_o(cur_tap_o), .dly_ld_o(dly_ld_o), .dly_adj_o(dly_adj_o),
    .dly_incdec_o(dly_incdec_o), .dly_tap_value_i(tap_q)
  );

  // I_DELAY model: load returns to tap 0, adj steps by one tap.
  always @(posedge clk) begin
    if (preset_en) tap_q <= preset_val;
    else if (dly_ld_o) tap_q <= '0;
    else if (dly_adj_o && !ignore_adj) tap_q <= dly_incdec_o ? tap_q + 1'b1 : tap_q - 1'b1;
  end

  // Scoreboard counters.
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Driver: force the model tap to a value.
  task automatic preset_tap(input logic [TAP_W-1:0] v);
    @(negedge clk);
    preset_val = v;
    preset_en  = 1'b1;
    @(negedge clk);
    preset_en  = 1'b0;
  endtask

  // Driver and monitor: issue one request and observe it to completion.
  task automatic run_txn(input logic [TAP_W-1:0] tgt, input logic ld, input logic hold,
                         input int budget, output int ack_cyc, output int ack_cnt,
                         output int ld_cnt, output int adj_cnt, output int inc_cnt,
                         output int done_cyc, output logic busy_after,
                         output logic err_at_done);
    ack_cyc = -1; ack_cnt = 0; ld_cnt = 0; adj_cnt = 0; inc_cnt = 0;
    done_cyc = -1; busy_after = 1'b1; err_at_done = 1'b0;
    @(negedge clk);
    req = 1'b1; target = tgt; load = ld;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (!hold) req = 1'b0;
      if (ack_o) begin
        ack_cnt++;
        if (ack_cyc < 0) ack_cyc = k;
      end
      if (dly_ld_o) ld_cnt++;
      if (dly_adj_o) begin
        adj_cnt++;
        if (dly_incdec_o) inc_cnt++;
      end
      if (done_o) begin
        done_cyc    = k;
        err_at_done = err_o;
        req = 1'b0;
        @(negedge clk);
        busy_after = busy_o;
        if (ack_o) ack_cnt++;
        break;
      end
    end
    req = 1'b0;
  endtask

  int   ack_cyc, ack_cnt, ld_cnt, adj_cnt, inc_cnt, done_cyc;
  logic busy_after, err_at_done;

  initial begin
    // Reset state.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs",
             {24'd0, ack_o, busy_o, done_o, err_o, dly_ld_o, dly_adj_o, dly_incdec_o, 1'b0}, 32'd0);
    check_eq("reset_cur_tap", cur_tap_o, 0);
    rst = 1'b0;

    // Tap 10 -> 13: three increments, done at cycle 20.
    preset_tap(6'd10);
    run_txn(6'd13, 1'b0, 1'b0, 60, ack_cyc, ack_cnt, ld_cnt, adj_cnt, inc_cnt, done_cyc,
            busy_after, err_at_done);
    check_eq("up_ack_cycle", ack_cyc, 1);
    check_eq("up_adj_count", adj_cnt, 3);
    check_eq("up_inc_count", inc_cnt, 3);
    check_eq("up_ld_count", ld_cnt, 0);
    check_eq("up_done_cycle", done_cyc, 20);
    check_eq("up_cur_tap", cur_tap_o, 13);
    check_eq("up_busy_after", busy_after, 0);
    check_eq("up_err", err_at_done, 0);

    // Tap 40 -> 38: two decrements.
    preset_tap(6'd40);
    run_txn(6'd38, 1'b0, 1'b0, 60, ack_cyc, ack_cnt, ld_cnt, adj_cnt, inc_cnt, done_cyc,
            busy_after, err_at_done);
    check_eq("down_adj_count", adj_cnt, 2);
    check_eq("down_inc_count", inc_cnt, 0);
    check_eq("down_done_cycle", done_cyc, 14);
    check_eq("down_cur_tap", cur_tap_o, 38);

    // Load then 20 increments from the reloaded tap 0.
    preset_tap(6'd33);
    run_txn(6'd20, 1'b1, 1'b0, 200, ack_cyc, ack_cnt, ld_cnt, adj_cnt, inc_cnt, done_cyc,
            busy_after, err_at_done);
    check_eq("load_ld_count", ld_cnt, 1);
    check_eq("load_adj_count", adj_cnt, 20);
    check_eq("load_inc_count", inc_cnt, 20);
    check_eq("load_done_cycle", done_cyc, 127);
    check_eq("load_busy_after", busy_after, 0);
    check_eq("load_cur_tap", cur_tap_o, 20);

    // Target 63 clamps to 50 at tap 50; req held during busy.
    preset_tap(6'd50);
    run_txn(6'd63, 1'b0, 1'b1, 20, ack_cyc, ack_cnt, ld_cnt, adj_cnt, inc_cnt, done_cyc,
            busy_after, err_at_done);
    check_eq("clamp_adj_count", adj_cnt, 0);
    check_eq("clamp_done_cycle", done_cyc, 2);
    check_eq("clamp_ack_count", ack_cnt, 1);
    check_eq("clamp_cur_tap", cur_tap_o, 50);

    // Tap 52 above the clamp: target 60 becomes 50, two decrements.
    preset_tap(6'd52);
    run_txn(6'd60, 1'b0, 1'b0, 60, ack_cyc, ack_cnt, ld_cnt, adj_cnt, inc_cnt, done_cyc,
            busy_after, err_at_done);
    check_eq("clamp_dn_adj_count", adj_cnt, 2);
    check_eq("clamp_dn_inc_count", inc_cnt, 0);
    check_eq("clamp_dn_cur_tap", cur_tap_o, 50);

    // Reset asserted while dly_adj_o is high.
    preset_tap(6'd0);
    @(negedge clk);
    req = 1'b1; target = 6'd30; load = 1'b0;
    begin
      int found;
      found = 0;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        req = 1'b0;
        if (dly_adj_o) begin
          found = 1;
          break;
        end
      end
      check_eq("rst_saw_adj", found, 1);
    end
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_outputs",
             {24'd0, ack_o, busy_o, done_o, err_o, dly_ld_o, dly_adj_o, dly_incdec_o, 1'b0}, 32'd0);
    check_eq("rst_mid_cur_tap", cur_tap_o, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    begin
      int adj_seen, busy_seen;
      adj_seen = 0; busy_seen = 0;
      repeat (20) begin
        @(negedge clk);
        if (dly_adj_o) adj_seen++;
        if (busy_o || done_o) busy_seen++;
      end
      check_eq("rst_no_adj_after", adj_seen, 0);
      check_eq("rst_idle_after", busy_seen, 0);
    end
    preset_tap(6'd7);
    run_txn(6'd7, 1'b0, 1'b0, 20, ack_cyc, ack_cnt, ld_cnt, adj_cnt, inc_cnt, done_cyc,
            busy_after, err_at_done);
    check_eq("rst_recover_ack", ack_cyc, 1);
    check_eq("rst_recover_done", done_cyc, 2);

`ifdef IDLY_CTRL_STEP_TIMEOUT_EN
    // Primitive ignores DLY_ADJ: watchdog fires after 16 steps.
    ignore_adj = 1'b1;
    preset_tap(6'd0);
    run_txn(6'd5, 1'b0, 1'b0, 200, ack_cyc, ack_cnt, ld_cnt, adj_cnt, inc_cnt, done_cyc,
            busy_after, err_at_done);
    check_eq("to_adj_count", adj_cnt, 16);
    check_eq("to_done_cycle", done_cyc, 98);
    check_eq("to_err", err_at_done, 1);
    check_eq("to_err_sticky", err_o, 1);
    ignore_adj = 1'b0;
    preset_tap(6'd3);
    run_txn(6'd3, 1'b0, 1'b0, 20, ack_cyc, ack_cnt, ld_cnt, adj_cnt, inc_cnt, done_cyc,
            busy_after, err_at_done);
    check_eq("to_err_cleared", err_at_done, 0);
    check_eq("to_next_done", done_cyc, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/i_delay_tap_ctrl.md
Name: i_delay_tap_ctrl

Overview:
Sequencing controller for one I_DELAY input-delay primitive. It accepts a requested tap value from fabric logic over a req/ack handshake, optionally reloads the primitive's default delay, then issues single-step DLY_ADJ pulses with the correct DLY_INCDEC direction until DLY_TAP_VALUE equals the target. It sits between calibration/training logic and the I_DELAY control pins, and is the only driver of DLY_LOAD, DLY_ADJ and DLY_INCDEC.

Parameters:
TAP_W, 6, width of the tap value; matches I_DELAY DLY_TAP_VALUE.
MAX_TAP, 63, highest legal tap; targets above it are clamped to MAX_TAP.
SETTLE_CYCLES, 4, idle cycles after each DLY_LOAD or DLY_ADJ pulse before the tap is resampled; legal range 1..255.
TIMEOUT_CYCLES, 16, step watchdog limit; used only when IDLY_CTRL_STEP_TIMEOUT_EN is defined.

Ports:
clk_i  in  1  clock; the same clock feeds I_DELAY CLK_IN.
rst_i  in  1  reset, synchronous, active-high.
req_i  in  1  request; sampled only in IDLE.
load_i  in  1  sampled with req_i; 1 = pulse DLY_LOAD before stepping.
target_tap_i  in  TAP_W  requested tap; sampled with req_i.
ack_o  out  1  one-cycle pulse in the cycle after a request is accepted.
busy_o  out  1  high from acceptance until the cycle after done_o.
done_o  out  1  one-cycle completion pulse.
err_o  out  1  sticky error flag; cleared by the next accepted request.
cur_tap_o  out  TAP_W  last sampled DLY_TAP_VALUE.
dly_ld_o  out  1  to I_DELAY DLY_LOAD.
dly_adj_o  out  1  to I_DELAY DLY_ADJ.
dly_incdec_o  out  1  to I_DELAY DLY_INCDEC; 1 = increment, 0 = decrement.
dly_tap_value_i  in  TAP_W  from I_DELAY DLY_TAP_VALUE.

Behaviour:
- Clock and reset: one clock, clk_i; reset is synchronous and active-high on rst_i.
- Registered outputs: all outputs are registered.
- Reset values: all outputs are 0; cur_tap_o = 0; state = IDLE.
- Reset mid-operation: at the next edge, any in-flight ld/adj pulse is dropped and the FSM returns to IDLE; no done_o is issued.
- FSM states: IDLE, LOAD, WAIT, CMP, ADJ, DONE.
- IDLE:
  - If req_i = 1, latch target = min(target_tap_i, MAX_TAP) and load_i.
  - Set ack_o and busy_o, clear err_o.
  - Next state is LOAD if load_i = 1, else CMP.
  - req_i while busy_o = 1 is ignored and not queued.
- LOAD: dly_ld_o = 1 for exactly one cycle, then WAIT.
- WAIT: counts SETTLE_CYCLES cycles with ld, adj and incdec held stable, then CMP.
- CMP (one cycle): sample dly_tap_value_i into cur_tap_o.
  - Equal to target: go to DONE.
  - Below target: set dly_incdec_o = 1, go to ADJ.
  - Above target: set dly_incdec_o = 0, go to ADJ.
- ADJ: dly_adj_o = 1 for exactly one cycle, with dly_incdec_o already stable since the prior cycle; then WAIT.
- dly_incdec_o holds its value until the next CMP decision.
- DONE: done_o = 1 for one cycle, then IDLE; busy_o drops in the following cycle.
- Latency, request accepted at edge 0, load_i = 0:
  - Equal target: CMP at cycle 1, done_o at cycle 2.
  - Each step costs SETTLE_CYCLES + 2 cycles.
  - load_i = 1 adds SETTLE_CYCLES + 1 cycles.
- Boundaries:
  - Because the target is clamped, no increment is issued at MAX_TAP and no decrement at 0.
  - Direction is re-decided every CMP, so overshoot caused by an external tap change self-corrects.

Optional Feature:
IDLY_CTRL_STEP_TIMEOUT_EN
- Defined: a step watchdog is compiled in.
  - It records the tap value before each ADJ.
  - If the tap sampled in CMP is unchanged, an unchanged-step counter increments; any change clears it.
  - When the counter reaches TIMEOUT_CYCLES, err_o is set and the FSM goes to DONE (done_o still pulses).
- Undefined: no watchdog logic; err_o is tied 0 and stepping continues until the tap matches.

Test Plan:
- Reset: hold rst_i for 3 cycles mid-ADJ -> all outputs 0 at the next edge; dly_adj_o never high afterwards; FSM back in IDLE.
- Tap 10, req target 13, load_i 0, SETTLE_CYCLES 4 -> ack_o at cycle 1; 3 dly_adj_o pulses with dly_incdec_o = 1; done_o at cycle 20; cur_tap_o = 13.
- Tap 40, target 38 -> 2 pulses with dly_incdec_o = 0; done_o; cur_tap_o = 38.
- Target 20 with load_i 1, model loads tap 0 -> one dly_ld_o pulse, then 20 increment pulses, done_o, busy_o low afterwards.
- MAX_TAP 50, target 63, start tap 50 -> zero adj pulses; done_o at cycle 2; req_i held high during busy produces no second ack_o.
- With IDLY_CTRL_STEP_TIMEOUT_EN and a model that ignores DLY_ADJ, target 5 from tap 0 -> 16 adj pulses, then err_o = 1 and done_o; the next request clears err_o.
